// File: rtl/store_buf.sv
// Posted store buffer: aligns core stores into 64-bit lane data plus byte mask
// and drains them in order to memory. Define STORE_BUF_FWD_EN to enable ld_hit.
module store_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [1:0]    st_size,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  output logic [$clog2(DEPTH):0] count,
  output logic          idle,
  output logic          misalign_err,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [7:0] raw_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Expands the byte mask to bits so bytes above the store size read as zero.
  function automatic logic [DW-1:0] size_data(input logic [DW-1:0] d,
                                               input logic [1:0]    size);
    logic [7:0]    m;
    logic [DW-1:0] bm;
    m  = raw_mask(size);
    bm = '0;
    for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{m[b]}};
    return d & bm;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = off[0];
      2'd2:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

  logic [AW-4:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [7:0]    mask_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    off_p0;
  logic          mis_p0;
  logic [7:0]    mask_p0;
  logic [DW-1:0] data_p0;
  logic          hs_p0, push_p0, pop;

  // Stage p0: combinational alignment of the incoming request
  assign off_p0  = st_addr[2:0];
  assign mis_p0  = is_misaligned(st_size, off_p0);
  assign mask_p0 = raw_mask(st_size) << off_p0;
  assign data_p0 = size_data(st_data, st_size) << {off_p0, 3'b000};

  assign st_ready   = (count != CW'(DEPTH));
  assign hs_p0      = st_valid && st_ready;
  assign push_p0    = hs_p0 && !mis_p0;
  assign mem_wvalid = (count != '0);
  assign pop        = mem_wvalid && mem_wready;
  assign idle       = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (hs_p0 && mis_p0) misalign_err <= 1'b1;
    end
  end

  // Stage p1: entry storage, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push_p0) begin
      addr_mem[wr_ptr] <= st_addr[AW-1:3];
      data_mem[wr_ptr] <= data_p0;
      mask_mem[wr_ptr] <= mask_p0;
    end
  end

  assign mem_waddr = {addr_mem[rd_ptr], 3'b000};
  assign mem_wdata = data_mem[rd_ptr];
  assign mem_wmask = mask_mem[rd_ptr];

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] rel [DEPTH];
  logic [DEPTH-1:0] hit_vec;
  logic unused_ld_low;
  assign unused_ld_low = ^ld_addr[2:0];

  // An entry is occupied when its distance from the head is below count.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]     = PW'(i) - rd_ptr;
      hit_vec[i] = ({1'b0, rel[i]} < count) && (addr_mem[i] == ld_addr[AW-1:3]);
    end
  end
  assign ld_hit = |hit_vec;
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit = 1'b0;
`endif

endmodule
